io_bus_ctrl: RTL and testbench

- Slave-side controller for the 16-bit HPS-to-FPGA IO bridge (io_address/io_bus_enable/io_rw/io_acknowledge/io_irq).
- Decodes each bridge access into one of NUM_SLAVES peripheral regions and sequences the handshake with wait states and timeout.
- Issues a single-cycle acknowledge and aggregates peripheral interrupts, through an internal pending/mask register bank, into io_irq.

---
 rtl/io_bus_ctrl_if.sv | 29 ++
 rtl/io_bus_ctrl.sv | 170 +++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : io_bus_ctrl_if
// Brief  : HPS-to-FPGA 16-bit IO bridge signal bundle (bridge = master).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface io_bus_ctrl_if;
    logic [15:0] io_address;
    logic        io_bus_enable;
    logic [1:0]  io_byte_enable;
    logic        io_rw;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;

    modport master (
        output io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
        input  io_read_data, io_acknowledge, io_irq
    );

    modport slave (
        input  io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
        output io_read_data, io_acknowledge, io_irq
    );
endinterface

`default_nettype wire

// File: rtl/io_bus_ctrl.sv
//------------------------------------------------------------------------------
// Module : io_bus_ctrl
// Brief  : IO bridge slave controller: region decode, wait/timeout handshake,
//          single-cycle ack and pending/mask interrupt aggregation.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_bus_ctrl #(
    parameter int          NUM_SLAVES = 4,
    parameter int          TIMEOUT    = 255,
    parameter logic [15:0] ERR_DATA   = 16'hDEAD
) (
    input  wire logic                      clk,
    input  wire logic                      reset_n,
    io_bus_ctrl_if.slave                   bus,
    output logic [NUM_SLAVES-1:0]          s_sel,
    output logic [11:0]                    s_addr,
    output logic                           s_rw,
    output logic [1:0]                     s_byte_enable,
    output logic [15:0]                    s_write_data,
    input  wire logic [16*NUM_SLAVES-1:0]  s_read_data,
    input  wire logic [NUM_SLAVES-1:0]     s_ready,
    input  wire logic [NUM_SLAVES-1:0]     s_irq
);

    localparam logic [4:0]  C_NUM_SLAVES = 5'(NUM_SLAVES);
    localparam logic [15:0] C_TO_LAST    = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_INTREG  = 3'd2,
        S_ERR     = 3'd3,
        S_ACK     = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t                r_state;
    logic [3:0]            r_region;
    logic [15:0]           r_cnt;
    logic [NUM_SLAVES-1:0] r_pending;
    logic [NUM_SLAVES-1:0] r_mask;
    logic [1:0]            r_status;
    logic [3:0]            r_stat_region;

    logic [3:0]            w_region;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic [15:0]           w_slice;
    logic                  w_hit;
    logic [15:0]           w_reg_rd;
    logic                  w_reg_wr;
    logic [NUM_SLAVES-1:0] w_w1c;

    assign w_region = bus.io_address[15:12];
    assign w_hit    = |(s_ready & s_sel);
    // Register writes only take effect on the low byte lane; all live bits sit there.
    assign w_reg_wr = (r_state == S_INTREG) && !s_rw && s_byte_enable[0];
    assign w_w1c    = (w_reg_wr && s_addr[3:1] == 3'd0) ? s_write_data[NUM_SLAVES-1:0] : '0;

    always_comb begin
        w_onehot = '0;
        w_slice  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_region == 4'(i)) w_onehot[i] = 1'b1;
            if (s_sel[i])          w_slice     = w_slice | s_read_data[16*i +: 16];
        end
    end

    always_comb begin
        w_reg_rd = '0;
        case (s_addr[3:1])
            3'd0:    w_reg_rd = 16'(r_pending);
            3'd1:    w_reg_rd = 16'(r_mask);
            3'd2:    w_reg_rd = {4'b0, r_stat_region, 6'b0, r_status};
            default: w_reg_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= S_IDLE;
            r_region           <= '0;
            r_cnt              <= '0;
            r_pending          <= '0;
            r_mask             <= '0;
            r_status           <= '0;
            r_stat_region      <= '0;
            s_sel              <= '0;
            s_addr             <= '0;
            s_rw               <= 1'b0;
            s_byte_enable      <= '0;
            s_write_data       <= '0;
            bus.io_read_data   <= '0;
            bus.io_acknowledge <= 1'b0;
            bus.io_irq         <= 1'b0;
        end else begin
            // New requests win over a same-cycle W1C.
            r_pending  <= (r_pending & ~w_w1c) | s_irq;
            bus.io_irq <= |(r_pending & r_mask);

            case (r_state)
                S_IDLE: begin
                    if (bus.io_bus_enable) begin
                        s_addr        <= bus.io_address[11:0];
                        s_rw          <= bus.io_rw;
                        s_byte_enable <= bus.io_byte_enable;
                        s_write_data  <= bus.io_write_data;
                        r_region      <= w_region;
                        r_cnt         <= '0;
                        if ({1'b0, w_region} < C_NUM_SLAVES) begin
                            s_sel   <= w_onehot;
                            r_state <= S_ACCESS;
                        end else if (w_region == 4'hF) begin
                            r_state <= S_INTREG;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end

                S_ACCESS: begin
                    if (w_hit) begin
                        s_sel              <= '0;
                        bus.io_acknowledge <= 1'b1;
                        bus.io_read_data   <= s_rw ? w_slice : 16'h0;
                        r_state            <= S_ACK;
                    end else if (r_cnt == C_TO_LAST) begin
                        s_sel              <= '0;
                        bus.io_acknowledge <= 1'b1;
                        bus.io_read_data   <= s_rw ? ERR_DATA : 16'h0;
                        r_status[0]        <= 1'b1;
                        r_stat_region      <= r_region;
                        r_state            <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_INTREG: begin
                    bus.io_acknowledge <= 1'b1;
                    bus.io_read_data   <= s_rw ? w_reg_rd : 16'h0;
                    if (w_reg_wr && s_addr[3:1] == 3'd1) r_mask <= s_write_data[NUM_SLAVES-1:0];
                    if (w_reg_wr && s_addr[3:1] == 3'd2) r_status <= r_status & ~s_write_data[1:0];
                    r_state <= S_ACK;
                end

                S_ERR: begin
                    bus.io_acknowledge <= 1'b1;
                    bus.io_read_data   <= s_rw ? ERR_DATA : 16'h0;
                    r_status[1]        <= 1'b1;
                    r_state            <= S_ACK;
                end

                S_ACK: begin
                    bus.io_acknowledge <= 1'b0;
                    bus.io_read_data   <= '0;
                    r_state            <= S_RECOVER;
                end

                S_RECOVER: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_bus_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_io_bus_ctrl
// Brief  : Self-checking bench for io_bus_ctrl (vector table, corner sequences,
//          randomized accesses against a register/latency reference model).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_bus_ctrl;
    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [15:0] ERRD = 16'hDEAD;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    io_bus_ctrl_if bus ();
    logic [NS-1:0]    s_sel;
    logic [11:0]      s_addr;
    logic             s_rw;
    logic [1:0]       s_byte_enable;
    logic [15:0]      s_write_data;
    logic [16*NS-1:0] s_read_data;
    logic [NS-1:0]    s_ready;
    logic [NS-1:0]    s_irq;

    io_bus_ctrl #(.NUM_SLAVES(NS), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .s_sel(s_sel), .s_addr(s_addr), .s_rw(s_rw), .s_byte_enable(s_byte_enable),
        .s_write_data(s_write_data), .s_read_data(s_read_data),
        .s_ready(s_ready), .s_irq(s_irq)
    );

    // Peripheral models: slave i answers after wait_cfg[i] selected cycles.
    int          wait_cfg [NS];
    logic [15:0] data_cfg [NS];
    logic [NS-1:0] noise;
    int          sel_cnt  [NS];
    int          sel_total = 0;
    logic [NS-1:0] mon_sel;
    logic [11:0] mon_addr;
    logic [15:0] mon_wd;
    logic [1:0]  mon_be;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) sel_cnt[i] <= s_sel[i] ? sel_cnt[i] + 1 : 0;
        if (|s_sel) begin
            sel_total <= sel_total + 1;
            mon_sel   <= s_sel;
            mon_addr  <= s_addr;
            mon_wd    <= s_write_data;
            mon_be    <= s_byte_enable;
        end
    end

    always_comb begin
        s_ready     = '0;
        s_read_data = '0;
        for (int i = 0; i < NS; i++) begin
            s_ready[i] = s_sel[i] ? (sel_cnt[i] == wait_cfg[i]) : noise[i];
            s_read_data[16*i +: 16] = data_cfg[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic end_access();
        repeat (2) begin
            @(posedge clk); #1;
            check("single_ack", 32'(bus.io_acknowledge), 32'd0);
        end
        @(negedge clk);
        bus.io_bus_enable = 1'b0;
        @(posedge clk); #1;
        check("no_reaccept", 32'(bus.io_acknowledge), 32'd0);
    endtask

    task automatic access(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                          input logic [15:0] wd, output logic [15:0] rd, output int lat);
        @(negedge clk);
        bus.io_address = addr; bus.io_rw = rw; bus.io_byte_enable = be;
        bus.io_write_data = wd; bus.io_bus_enable = 1'b1;
        lat = -1; rd = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.io_acknowledge) begin lat = c; rd = bus.io_read_data; break; end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL ack_wait: no acknowledge within 40 cycles for addr %h", addr);
            @(negedge clk); bus.io_bus_enable = 1'b0;
        end else begin
            end_access();
        end
    endtask

    typedef struct {
        logic [15:0] addr; logic rw; logic [1:0] be; logic [15:0] wd;
        int wt; logic [15:0] sdata;
        logic [15:0] exp_rd; int exp_lat; int exp_cyc; logic [3:0] exp_sel;
    } vec_t;
    vec_t vt [9];

    // Reference model state
    logic [3:0] m_pend, m_mask, m_reg;
    logic       m_to, m_un;

    logic [15:0] rd;
    int lat, base, r, w, kind;
    logic rw;
    logic [1:0] be;
    logic [15:0] wd, addr, exp_rd;
    int exp_lat, exp_cyc;
    logic [3:0] p;

    initial begin
        bus.io_address = '0; bus.io_bus_enable = 1'b0; bus.io_byte_enable = '0;
        bus.io_rw = 1'b0; bus.io_write_data = '0;
        s_irq = '0; noise = '0;
        for (int i = 0; i < NS; i++) begin wait_cfg[i] = 100; data_cfg[i] = '0; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(bus.io_acknowledge), 32'd0);
        check("rst_rdata", 32'(bus.io_read_data),   32'd0);
        check("rst_irq",   32'(bus.io_irq),         32'd0);
        check("rst_sel",   32'(s_sel),              32'd0);
        @(negedge clk) reset_n = 1'b1;

        vt[0] = '{16'h1004, 1'b1, 2'b11, 16'h0000,   0, 16'h1234, 16'h1234, 2, 1, 4'b0010};
        vt[1] = '{16'h3000, 1'b0, 2'b01, 16'hA5A5,   5, 16'h5555, 16'h0000, 7, 6, 4'b1000};
        vt[2] = '{16'h0010, 1'b1, 2'b11, 16'h0000,   7, 16'hBEEF, 16'hBEEF, 9, 8, 4'b0001};
        vt[3] = '{16'h2000, 1'b1, 2'b11, 16'h0000, 100, 16'h7777, 16'hDEAD, 9, 8, 4'b0100};
        vt[4] = '{16'hF004, 1'b1, 2'b11, 16'h0000,   0, 16'h0000, 16'h0201, 2, 0, 4'b0000};
        vt[5] = '{16'h7000, 1'b1, 2'b11, 16'h0000,   0, 16'h0000, 16'hDEAD, 2, 0, 4'b0000};
        vt[6] = '{16'hF004, 1'b1, 2'b11, 16'h0000,   0, 16'h0000, 16'h0203, 2, 0, 4'b0000};
        vt[7] = '{16'hF004, 1'b0, 2'b01, 16'h0002,   0, 16'h0000, 16'h0000, 2, 0, 4'b0000};
        vt[8] = '{16'hF004, 1'b1, 2'b11, 16'h0000,   0, 16'h0000, 16'h0201, 2, 0, 4'b0000};

        noise = 4'hF;
        foreach (vt[k]) begin
            if (vt[k].exp_sel != 0) begin
                wait_cfg[vt[k].addr[13:12]] = vt[k].wt;
                data_cfg[vt[k].addr[13:12]] = vt[k].sdata;
            end
            base = sel_total;
            access(vt[k].addr, vt[k].rw, vt[k].be, vt[k].wd, rd, lat);
            check($sformatf("vec%0d_lat", k),  32'(lat), 32'(vt[k].exp_lat));
            check($sformatf("vec%0d_rd", k),   32'(rd),  32'(vt[k].exp_rd));
            check($sformatf("vec%0d_selcyc", k), 32'(sel_total - base), 32'(vt[k].exp_cyc));
            if (vt[k].exp_sel != 0) begin
                check($sformatf("vec%0d_sel", k),  32'(mon_sel),  32'(vt[k].exp_sel));
                check($sformatf("vec%0d_addr", k), 32'(mon_addr), 32'(vt[k].addr[11:0]));
                if (!vt[k].rw) begin
                    check($sformatf("vec%0d_wd", k), 32'(mon_wd), 32'(vt[k].wd));
                    check($sformatf("vec%0d_be", k), 32'(mon_be), 32'(vt[k].be));
                end
            end
        end
        noise = '0;

        // Interrupt path: masked pulse, unmask, then W1C racing a new request.
        @(negedge clk) s_irq = 4'b0100;
        @(negedge clk) s_irq = '0;
        repeat (3) @(posedge clk);
        #1 check("irq_masked", 32'(bus.io_irq), 32'd0);
        access(16'hF000, 1'b1, 2'b11, 16'h0, rd, lat);
        check("pend_read", 32'(rd), 32'h0004);
        access(16'hF002, 1'b0, 2'b01, 16'h0004, rd, lat);
        check("irq_unmasked", 32'(bus.io_irq), 32'd1);

        @(negedge clk);
        bus.io_address = 16'hF000; bus.io_rw = 1'b0; bus.io_byte_enable = 2'b01;
        bus.io_write_data = 16'h0004; bus.io_bus_enable = 1'b1;
        @(posedge clk);
        @(negedge clk) s_irq = 4'b0100;
        @(posedge clk);
        #1 check("w1c_ack", 32'(bus.io_acknowledge), 32'd1);
        @(negedge clk) s_irq = '0;
        end_access();
        access(16'hF000, 1'b1, 2'b11, 16'h0, rd, lat);
        check("set_wins_w1c", 32'(rd), 32'h0004);
        check("irq_still", 32'(bus.io_irq), 32'd1);

        // Reset in the third ACCESS cycle of a stalled read.
        wait_cfg[0] = 100;
        @(negedge clk);
        bus.io_address = 16'h0000; bus.io_rw = 1'b1; bus.io_byte_enable = 2'b11;
        bus.io_bus_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) begin reset_n = 1'b0; bus.io_bus_enable = 1'b0; end
        #1;
        check("mid_rst_sel",  32'(s_sel),            32'd0);
        check("mid_rst_addr", 32'(s_addr),           32'd0);
        check("mid_rst_irq",  32'(bus.io_irq),       32'd0);
        check("mid_rst_rd",   32'(bus.io_read_data), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("mid_rst_ack", 32'(bus.io_acknowledge), 32'd0);
        end
        @(negedge clk) reset_n = 1'b1;
        access(16'hF000, 1'b1, 2'b11, 16'h0, rd, lat);
        check("rst_pend", 32'(rd), 32'h0);
        access(16'hF002, 1'b1, 2'b11, 16'h0, rd, lat);
        check("rst_mask", 32'(rd), 32'h0);
        access(16'hF004, 1'b1, 2'b11, 16'h0, rd, lat);
        check("rst_status", 32'(rd), 32'h0);
        wait_cfg[1] = 0; data_cfg[1] = 16'h1234;
        access(16'h1004, 1'b1, 2'b11, 16'h0, rd, lat);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_rd",  32'(rd),  32'h1234);

        // Randomized accesses against the reference model.
        m_pend = '0; m_mask = '0; m_reg = '0; m_to = 1'b0; m_un = 1'b0;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 3);
            rw = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            noise = 4'($urandom);
            exp_cyc = 0; exp_lat = 2;
            if (kind <= 1) begin
                r = $urandom_range(0, NS - 1);
                w = $urandom_range(0, 10);
                wait_cfg[r] = w;
                data_cfg[r] = 16'($urandom);
                addr = {4'(r), 12'($urandom)};
                if (w <= TO - 1) begin
                    exp_lat = 2 + w; exp_cyc = w + 1;
                    exp_rd = rw ? data_cfg[r] : 16'h0;
                end else begin
                    exp_lat = TO + 1; exp_cyc = TO;
                    exp_rd = rw ? ERRD : 16'h0;
                    m_to = 1'b1; m_reg = 4'(r);
                end
            end else if (kind == 2) begin
                addr = {4'hF, 12'($urandom)};
                case (addr[3:1])
                    3'd0:    exp_rd = {12'h0, m_pend};
                    3'd1:    exp_rd = {12'h0, m_mask};
                    3'd2:    exp_rd = {4'h0, m_reg, 6'h0, m_un, m_to};
                    default: exp_rd = 16'h0;
                endcase
                if (!rw) exp_rd = 16'h0;
                if (!rw && be[0]) begin
                    if (addr[3:1] == 3'd0) m_pend = m_pend & ~wd[3:0];
                    if (addr[3:1] == 3'd1) m_mask = wd[3:0];
                    if (addr[3:1] == 3'd2) begin
                        m_to = m_to & ~wd[0];
                        m_un = m_un & ~wd[1];
                    end
                end
            end else begin
                addr = {4'($urandom_range(NS, 14)), 12'($urandom)};
                exp_rd = rw ? ERRD : 16'h0;
                m_un = 1'b1;
            end
            base = sel_total;
            access(addr, rw, be, wd, rd, lat);
            check($sformatf("rnd%0d_lat", it),    32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_rd", it),     32'(rd),  32'(exp_rd));
            check($sformatf("rnd%0d_selcyc", it), 32'(sel_total - base), 32'(exp_cyc));
            check($sformatf("rnd%0d_irq", it),    32'(bus.io_irq), 32'(|(m_pend & m_mask)));
            if ($urandom_range(0, 3) == 0) begin
                p = 4'($urandom);
                @(negedge clk) s_irq = p;
                @(negedge clk) s_irq = '0;
                m_pend = m_pend | p;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
